// File: rtl/julia_mem_arbiter.sv
// julia_mem_arbiter: serialises finished pixels from NUM_WORKERS julia workers onto one frame-buffer
// write port, with round-robin or fixed-priority grant and per-frame pixel counting.
module julia_mem_arbiter #(
  parameter int NUM_WORKERS   = 16,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int FRAME_PIXELS  = 307200,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                                  i_clk,
  input  logic                                  i_n_rst,
  input  logic                                  i_start_sig,
  input  logic [NUM_WORKERS-1:0]                i_jw_done,
  input  logic [NUM_WORKERS-1:0][DATA_W-1:0]    i_color,
  input  logic [NUM_WORKERS-1:0][ADDR_W-1:0]    i_address,
  output logic [NUM_WORKERS-1:0]                o_mc_done,
  output logic [NUM_WORKERS-1:0]                o_mc_busy,
  output logic [ADDR_W-1:0]                     o_wr_addr,
  output logic [DATA_W-1:0]                     o_wr_data,
  output logic                                  o_wr_ready,
  input  logic                                  i_wr_done,
  output logic [$clog2(FRAME_PIXELS)-1:0]       o_pixel_count,
  output logic                                  o_frame_done
);
  localparam int GW = $clog2(NUM_WORKERS);
  localparam int CW = $clog2(FRAME_PIXELS);
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RELEASE} state_t;
  state_t r_state, w_next;
  logic [GW-1:0] r_g, w_sel, w_rr_off, w_fp_sel, w_rr_sel;
  logic [GW:0] w_rr_sum;
  logic [NUM_WORKERS-1:0] r_mask, r_mc_done, w_elig, w_rot, w_g_oh;
  logic [2*NUM_WORKERS-1:0] w_dbl;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [CW-1:0] r_pixel_count;
  logic r_wr_ready, r_frame_done, w_any, w_rel_ack, w_grant, w_wrap;

  assign w_elig    = i_jw_done & ~r_mask;
  assign w_any     = |w_elig;
  assign w_g_oh    = {{(NUM_WORKERS-1){1'b0}}, 1'b1} << r_g;
  assign w_grant   = (r_state == S_IDLE) && w_any;
  assign w_rel_ack = (r_state == S_WRITE) && i_wr_done;
  assign w_wrap    = (r_pixel_count == CW'(FRAME_PIXELS - 1));
  // r_g doubles as the last grant: rotate so bit 0 is the worker just after it
  assign w_dbl     = {w_elig, w_elig} >> ({1'b0, r_g} + (GW+1)'(1));
  assign w_rot     = w_dbl[NUM_WORKERS-1:0];

  always_comb begin
    w_rr_off = '0;
    w_fp_sel = '0;
    for (int i = NUM_WORKERS - 1; i >= 0; i--) begin
      if (w_rot[i]) w_rr_off = GW'(i);
      if (w_elig[i]) w_fp_sel = GW'(i);
    end
  end

  assign w_rr_sum = {1'b0, r_g} + {1'b0, w_rr_off} + (GW+1)'(1);
  assign w_rr_sel = (w_rr_sum >= (GW+1)'(NUM_WORKERS)) ? GW'(w_rr_sum - (GW+1)'(NUM_WORKERS))
                                                       : GW'(w_rr_sum);
  assign w_sel    = (PRIORITY_MODE != 0) ? w_fp_sel : w_rr_sel;

  always_comb begin
    w_next = (r_state == S_WRITE) ? (i_wr_done ? S_RELEASE : S_WRITE)
           : (w_grant ? S_WRITE : S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_state       <= S_IDLE;
      r_g           <= GW'(NUM_WORKERS - 1);
      r_mask        <= '0;
      r_mc_done     <= '0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_wr_ready    <= 1'b0;
      r_pixel_count <= '0;
      r_frame_done  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_wr_ready   <= (w_next == S_WRITE);
      r_mc_done    <= w_rel_ack ? w_g_oh : '0;
      r_mask       <= (r_state == S_RELEASE) ? w_g_oh : '0;
      r_frame_done <= !i_start_sig && (r_state == S_RELEASE) && w_wrap;
      if (w_grant) begin
        r_g       <= w_sel;
        r_wr_addr <= i_address[w_sel];
        r_wr_data <= i_color[w_sel];
      end
      if (i_start_sig || ((r_state == S_RELEASE) && w_wrap)) r_pixel_count <= '0;
      else if (r_state == S_RELEASE) r_pixel_count <= r_pixel_count + CW'(1);
    end
  end

  assign o_mc_busy     = i_jw_done & ~((r_state == S_IDLE) ? {NUM_WORKERS{1'b0}} : w_g_oh);
  assign o_mc_done     = r_mc_done;
  assign o_wr_addr     = r_wr_addr;
  assign o_wr_data     = r_wr_data;
  assign o_wr_ready    = r_wr_ready;
  assign o_pixel_count = r_pixel_count;
  assign o_frame_done  = r_frame_done;
endmodule

// File: tb/tb_julia_mem_arbiter.sv
// tb_julia_mem_arbiter: directed and randomized checks of a round-robin and a fixed-priority arbiter
// against a transaction-level model of grant order, timing and frame counting.
module tb_julia_mem_arbiter;
  localparam int N  = 16;
  localparam int FP = 4;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic start_sig = 1'b0;
  logic wr_done = 1'b0;
  logic mode = 1'b0;
  logic [N-1:0] jw_done = '0;
  logic [N-1:0][31:0] color = '0;
  logic [N-1:0][31:0] address = '0;
  logic [N-1:0] mc_done_a, mc_done_b, mc_busy_a, mc_busy_b, mc_done, mc_busy;
  logic [31:0] wr_addr_a, wr_addr_b, wr_data_a, wr_data_b, wr_addr, wr_data;
  logic [1:0] cnt_a, cnt_b, pixel_count;
  logic rdy_a, rdy_b, wr_ready, fd_a, fd_b, frame_done;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  julia_mem_arbiter #(.NUM_WORKERS(N), .ADDR_W(32), .DATA_W(32), .FRAME_PIXELS(FP), .PRIORITY_MODE(0)) u_rr (
    .i_clk(clk), .i_n_rst(n_rst), .i_start_sig(start_sig), .i_jw_done(jw_done), .i_color(color),
    .i_address(address), .o_mc_done(mc_done_a), .o_mc_busy(mc_busy_a), .o_wr_addr(wr_addr_a),
    .o_wr_data(wr_data_a), .o_wr_ready(rdy_a), .i_wr_done(wr_done & ~mode), .o_pixel_count(cnt_a),
    .o_frame_done(fd_a));

  julia_mem_arbiter #(.NUM_WORKERS(N), .ADDR_W(32), .DATA_W(32), .FRAME_PIXELS(FP), .PRIORITY_MODE(1)) u_fp (
    .i_clk(clk), .i_n_rst(n_rst), .i_start_sig(start_sig), .i_jw_done(jw_done), .i_color(color),
    .i_address(address), .o_mc_done(mc_done_b), .o_mc_busy(mc_busy_b), .o_wr_addr(wr_addr_b),
    .o_wr_data(wr_data_b), .o_wr_ready(rdy_b), .i_wr_done(wr_done & mode), .o_pixel_count(cnt_b),
    .o_frame_done(fd_b));

  assign mc_done     = mode ? mc_done_b : mc_done_a;
  assign mc_busy     = mode ? mc_busy_b : mc_busy_a;
  assign wr_addr     = mode ? wr_addr_b : wr_addr_a;
  assign wr_data     = mode ? wr_data_b : wr_data_a;
  assign wr_ready    = mode ? rdy_b : rdy_a;
  assign pixel_count = mode ? cnt_b : cnt_a;
  assign frame_done  = mode ? fd_b : fd_a;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    n_rst = 1'b0; jw_done = '0; wr_done = 1'b0; start_sig = 1'b0;
    step();
    n_rst = 1'b1;
    step();
  endtask

  function automatic logic [N-1:0] oh(input int g);
    logic [N-1:0] one;
    one = 1;
    return one << g;
  endfunction

  // Spec rule: round-robin searches last+1.. modulo N, fixed priority takes the lowest index.
  function automatic int pick(input logic [N-1:0] req, input int last, input logic fixed);
    for (int k = 0; k < N; k++) begin
      int i;
      i = fixed ? k : (last + 1 + k) % N;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic test_reset();
    mode = 1'b0; n_rst = 1'b0; jw_done = '1; wr_done = 1'b0; start_sig = 1'b0;
    for (int i = 0; i < N; i++) begin address[i] = $urandom; color[i] = $urandom; end
    repeat (3) step();
    total++;
    if ({wr_ready, frame_done, mc_done, wr_addr, wr_data, pixel_count} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%0b fd=%0b mc_done=%h addr=%h data=%h cnt=%0d, want all zero",
               wr_ready, frame_done, mc_done, wr_addr, wr_data, pixel_count);
    end
    total++;
    if (mc_busy !== jw_done) begin bad++; $display("FAIL reset_busy: got %h want %h", mc_busy, jw_done); end
    n_rst = 1'b1;
    step();
    total++;
    if (wr_ready !== 1'b1 || wr_addr !== address[0] || wr_data !== color[0]) begin
      bad++;
      $display("FAIL reset_first_grant: rdy=%0b addr=%h data=%h want 1 %h %h", wr_ready, wr_addr, wr_data, address[0], color[0]);
    end
    wr_done = 1'b1; step(); wr_done = 1'b0; jw_done = '0;
    total++;
    if (mc_done !== oh(0)) begin bad++; $display("FAIL reset_first_done: got %h want %h", mc_done, oh(0)); end
    step();
    total++;
    if (pixel_count !== 2'd1) begin bad++; $display("FAIL reset_first_count: got %0d want 1", pixel_count); end
  endtask

  task automatic test_single_write();
    mode = 1'b0; do_reset();
    address[3] = 32'h0000_1234; color[3] = 32'h00FF_00FF;
    jw_done = oh(3);
    for (int c = 0; c < 2; c++) begin
      step();
      total++;
      if (wr_ready !== 1'b1 || wr_addr !== 32'h0000_1234 || wr_data !== 32'h00FF_00FF || mc_done !== '0) begin
        bad++;
        $display("FAIL single_hold%0d: rdy=%0b addr=%h data=%h mc_done=%h", c, wr_ready, wr_addr, wr_data, mc_done);
      end
    end
    wr_done = 1'b1; step(); wr_done = 1'b0; jw_done = '0;
    total++;
    if (mc_done !== oh(3) || wr_ready !== 1'b0) begin
      bad++; $display("FAIL single_release: mc_done=%h rdy=%0b want %h 0", mc_done, wr_ready, oh(3));
    end
    step();
    total++;
    if (mc_done !== '0 || pixel_count !== 2'd1) begin
      bad++; $display("FAIL single_after: mc_done=%h cnt=%0d want 0 1", mc_done, pixel_count);
    end
  endtask

  task automatic test_round_robin();
    mode = 1'b0; do_reset();
    for (int i = 0; i < N; i++) begin address[i] = {16'(i), 16'($urandom)}; color[i] = $urandom; end
    jw_done = '1;
    for (int k = 0; k <= N; k++) begin
      if (k > 0) step();
      step();
      total++;
      if (wr_ready !== 1'b1 || wr_addr !== address[k % N] || mc_busy !== ~oh(k % N)) begin
        bad++;
        $display("FAIL rr_grant%0d: rdy=%0b addr=%h busy=%h want addr %h busy %h", k, wr_ready, wr_addr, mc_busy,
                 address[k % N], ~oh(k % N));
      end
      wr_done = 1'b1; step(); wr_done = 1'b0;
      total++;
      if (mc_done !== oh(k % N)) begin bad++; $display("FAIL rr_done%0d: got %h want %h", k, mc_done, oh(k % N)); end
    end
    jw_done = '0;
  endtask

  task automatic test_mask();
    mode = 1'b0; do_reset();
    address[1] = 32'h0000_0111;
    jw_done = oh(1);
    step();
    wr_done = 1'b1; step(); wr_done = 1'b0;
    total++;
    if (mc_done !== oh(1)) begin bad++; $display("FAIL mask_done: got %h want %h", mc_done, oh(1)); end
    step();
    step();
    total++;
    if (wr_ready !== 1'b0) begin bad++; $display("FAIL mask_block: rdy=%0b want 0", wr_ready); end
    step();
    total++;
    if (wr_ready !== 1'b1 || wr_addr !== 32'h0000_0111) begin
      bad++; $display("FAIL mask_clear: rdy=%0b addr=%h want 1 00000111", wr_ready, wr_addr);
    end
    wr_done = 1'b1; step(); wr_done = 1'b0; jw_done = '0;
    step();
  endtask

  task automatic test_fixed();
    mode = 1'b1; do_reset();
    address[2] = 32'h0000_2222; address[5] = 32'h0000_5555;
    jw_done = oh(2) | oh(5);
    step();
    total++;
    if (wr_ready !== 1'b1 || wr_addr !== 32'h0000_2222 || mc_busy !== oh(5)) begin
      bad++; $display("FAIL fixed_first: rdy=%0b addr=%h busy=%h want 1 00002222 %h", wr_ready, wr_addr, mc_busy, oh(5));
    end
    wr_done = 1'b1; step(); wr_done = 1'b0; jw_done = oh(5);
    total++;
    if (mc_done !== oh(2)) begin bad++; $display("FAIL fixed_done2: got %h want %h", mc_done, oh(2)); end
    step(); step();
    total++;
    if (wr_ready !== 1'b1 || wr_addr !== 32'h0000_5555) begin
      bad++; $display("FAIL fixed_second: rdy=%0b addr=%h want 1 00005555", wr_ready, wr_addr);
    end
    wr_done = 1'b1; step(); wr_done = 1'b0; jw_done = '0;
    total++;
    if (mc_done !== oh(5)) begin bad++; $display("FAIL fixed_done5: got %h want %h", mc_done, oh(5)); end
    step();
    mode = 1'b0;
  endtask

  task automatic test_frame();
    mode = 1'b0; do_reset();
    address[7] = 32'h0000_7000; color[7] = 32'h0000_0007;
    for (int k = 0; k < 8; k++) begin
      jw_done = oh(7); step();
      wr_done = 1'b1; step();
      wr_done = 1'b0; jw_done = '0; start_sig = (k == 7);
      step();
      start_sig = 1'b0;
      total++;
      if (pixel_count !== 2'((k == 7) ? 0 : (k + 1) % FP) || frame_done !== (k == 3)) begin
        bad++;
        $display("FAIL frame%0d: cnt=%0d fd=%0b want %0d %0b", k, pixel_count, frame_done,
                 (k == 7) ? 0 : (k + 1) % FP, k == 3);
      end
      step();
      total++;
      if (frame_done !== 1'b0) begin bad++; $display("FAIL frame_pulse%0d: fd=%0b want 0", k, frame_done); end
    end
  endtask

  task automatic test_reset_mid_write();
    mode = 1'b0; do_reset();
    address[4] = 32'h0000_4444; color[4] = 32'h0000_0004;
    jw_done = oh(4); step();
    total++;
    if (wr_ready !== 1'b1) begin bad++; $display("FAIL rmw_pre: rdy=%0b want 1", wr_ready); end
    #2 n_rst = 1'b0;
    #1;
    total++;
    if (wr_ready !== 1'b0 || wr_addr !== '0) begin
      bad++; $display("FAIL rmw_async: rdy=%0b addr=%h want 0 0", wr_ready, wr_addr);
    end
    wr_done = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (mc_done !== '0 || wr_ready !== 1'b0 || pixel_count !== 2'd0) begin
        bad++; $display("FAIL rmw_held%0d: mc_done=%h rdy=%0b cnt=%0d want 0", c, mc_done, wr_ready, pixel_count);
      end
    end
    wr_done = 1'b0; n_rst = 1'b1;
    step();
    total++;
    if (wr_ready !== 1'b1 || wr_addr !== 32'h0000_4444) begin
      bad++; $display("FAIL rmw_restart: rdy=%0b addr=%h want 1 00004444", wr_ready, wr_addr);
    end
    wr_done = 1'b1; step(); wr_done = 1'b0; jw_done = '0;
    total++;
    if (mc_done !== oh(4)) begin bad++; $display("FAIL rmw_done: got %h want %h", mc_done, oh(4)); end
    step();
  endtask

  task automatic test_random(input logic m, input int ntx);
    logic [N-1:0] req, nw;
    int last, cnt, g, pg, w, b;
    logic st, efd;
    mode = m; do_reset();
    req = '0; last = N - 1; cnt = 0; pg = -1; efd = 1'b0;
    for (int t = 0; t < ntx; t++) begin
      nw = N'($urandom & $urandom);
      if (pg >= 0) nw[pg] = 1'b0;
      if ((req | nw) == '0) begin
        b = (pg + 1 + $urandom_range(0, N - 2)) % N;
        nw[b] = 1'b1;
      end
      for (int i = 0; i < N; i++)
        if (nw[i] && !req[i]) begin address[i] = $urandom; color[i] = $urandom; end
      req = req | nw;
      jw_done = req;
      if (pg >= 0) begin
        wr_done = 1'($urandom_range(0, 1));
        step();
        start_sig = 1'b0;
        total++;
        if (pixel_count !== 2'(cnt) || frame_done !== efd) begin
          bad++; $display("FAIL rand_count m=%0b t=%0d: cnt=%0d fd=%0b want %0d %0b", m, t, pixel_count, frame_done, cnt, efd);
        end
        total++;
        if (wr_ready !== 1'b0 || mc_done !== '0) begin
          bad++; $display("FAIL rand_idle m=%0b t=%0d: rdy=%0b mc_done=%h want 0 0", m, t, wr_ready, mc_done);
        end
        wr_done = 1'($urandom_range(0, 1));
      end
      g = pick(req, last, m);
      step();
      wr_done = 1'b0;
      total++;
      if (wr_ready !== 1'b1 || wr_addr !== address[g] || wr_data !== color[g] || mc_busy !== (req & ~oh(g)) ||
          frame_done !== 1'b0) begin
        bad++;
        $display("FAIL rand_grant m=%0b t=%0d: rdy=%0b addr=%h data=%h busy=%h fd=%0b want worker %0d addr=%h busy=%h",
                 m, t, wr_ready, wr_addr, wr_data, mc_busy, frame_done, g, address[g], req & ~oh(g));
      end
      w = $urandom_range(0, 3);
      repeat (w) begin
        step();
        total++;
        if (wr_ready !== 1'b1 || wr_addr !== address[g] || wr_data !== color[g] || mc_done !== '0) begin
          bad++; $display("FAIL rand_hold m=%0b t=%0d: rdy=%0b addr=%h mc_done=%h want 1 %h 0", m, t, wr_ready, wr_addr,
                          mc_done, address[g]);
        end
      end
      wr_done = 1'b1;
      step();
      total++;
      if (mc_done !== oh(g) || wr_ready !== 1'b0) begin
        bad++; $display("FAIL rand_release m=%0b t=%0d: mc_done=%h rdy=%0b want %h 0", m, t, mc_done, wr_ready, oh(g));
      end
      wr_done = 1'b0;
      req[g] = 1'b0;
      jw_done = req;
      if (!m) last = g;
      st = ($urandom_range(0, 3) == 0);
      start_sig = st;
      efd = !st && (cnt == FP - 1);
      cnt = st ? 0 : (cnt + 1) % FP;
      pg = g;
    end
    step();
    start_sig = 1'b0;
    total++;
    if (pixel_count !== 2'(cnt) || frame_done !== efd) begin
      bad++; $display("FAIL rand_final m=%0b: cnt=%0d fd=%0b want %0d %0b", m, pixel_count, frame_done, cnt, efd);
    end
    jw_done = '0;
    mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_mask();
    test_fixed();
    test_frame();
    test_reset_mid_write();
    test_random(1'b0, 40);
    test_random(1'b1, 40);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/julia_mem_arbiter.md
# julia_mem_arbiter

Parametrised memory controller that collects finished pixels from `NUM_WORKERS` julia workers and serialises them onto the single frame-buffer write port (`wr_addr`/`wr_data`/`wr_ready`/`wr_done`). It sits between the worker array and the bus master. It drives each worker's `MC_done`/busy handshake, grants in round-robin or fixed-priority order, and counts pixels to flag frame completion.

## Interface
- `NUM_WORKERS`, 16: number of worker channels, 2..64.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: colour/data width.
- `FRAME_PIXELS`, 307200: pixels per frame (640x480).
- `PRIORITY_MODE`, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- `clk` input, 1: system clock, rising edge.
- `n_rst` input, 1: reset, asynchronous, active-low.
- `start_sig` input, 1: one-cycle pulse that clears the pixel counter for a new frame.
- `jw_done` input, `NUM_WORKERS`: per-worker request level, held until that worker's `mc_done` pulse.
- `color` input, `[NUM_WORKERS-1:0]` x `DATA_W`: per-worker pixel colour, stable while `jw_done[i]` = 1.
- `address` input, `[NUM_WORKERS-1:0]` x `ADDR_W`: per-worker pixel address, stable while `jw_done[i]` = 1.
- `mc_done` output, `NUM_WORKERS`: one-cycle write-complete pulse to the granted worker.
- `mc_busy` output, `NUM_WORKERS`: `mc_busy[i]` = `jw_done[i]` and i is not the current grant (request waiting).
- `wr_addr` output, `ADDR_W`: write address, registered.
- `wr_data` output, `DATA_W`: write data, registered.
- `wr_ready` output, 1: write request to the bus master.
- `wr_done` input, 1: bus master acknowledge, one cycle.
- `pixel_count` output, `$clog2(FRAME_PIXELS)`: pixels written this frame.
- `frame_done` output, 1: one-cycle pulse when the last pixel of a frame completes.

## Operation
- FSM states: IDLE, WRITE, RELEASE.
- **IDLE**
  - Form the eligible set = `jw_done` & ~`mask`.
  - If the eligible set is non-empty: select grant `g`, latch `wr_addr`=`address[g]` and `wr_data`=`color[g]`, go to WRITE. Otherwise stay.
- **WRITE**
  - `wr_ready`=1. `wr_addr`/`wr_data`/`g` are held constant.
  - When `wr_done`=1: go to RELEASE.
- **RELEASE**
  - `mc_done[g]`=1 for exactly this cycle; `wr_ready`=0.
  - `pixel_count` increments. If it was `FRAME_PIXELS-1`: wrap to 0 and `frame_done`=1 this cycle.
  - Set `mask`=onehot(g) for the next IDLE cycle, then go to IDLE.
- `mask` is cleared after one IDLE cycle. This guards against re-granting a worker whose `jw_done` falls late.
- **Round-robin selection:** search indices `last+1 .. last+NUM_WORKERS` modulo `NUM_WORKERS`; first set bit wins; `last` is updated to `g` on entering WRITE.
- **Fixed-priority selection:** lowest set index wins; `last` is unused.
- Only one worker is ever granted. `mc_done` is one-hot or zero.
- `wr_done` seen outside WRITE is ignored.
- **`start_sig`**
  - Clears `pixel_count` to 0 next cycle.
  - If `start_sig` coincides with RELEASE, the clear wins and `frame_done` is suppressed.
  - An in-flight write still completes normally.
- `jw_done[i]` dropping before grant: the request is simply lost; no error.
- Reset values: state IDLE, `wr_ready`=0, `wr_addr`=0, `wr_data`=0, `mc_done`=0, `frame_done`=0, `pixel_count`=0, `mask`=0, `last`=`NUM_WORKERS-1` (worker 0 first).
- Reset asserted mid-WRITE: the write is abandoned, `wr_ready` drops immediately (asynchronously), and no `mc_done` is issued.

## Timing
- All outputs are registered, except `mc_busy` (combinational from `jw_done` and state/`g`).
- **Request to `wr_ready`:** `jw_done[i]` sampled high in IDLE at edge t → `wr_ready`=1 from cycle t+1.
- **`wr_done` to release:** `wr_done` sampled at edge k → RELEASE in cycle k+1 (`mc_done[g]`=1, `wr_ready`=0) → IDLE at k+2.
- **Throughput:** minimum 3 cycles per pixel (IDLE, WRITE with same-cycle `wr_done`, RELEASE).
- **Fairness:** with all `NUM_WORKERS` requesting continuously in round-robin mode, each worker is granted once per `NUM_WORKERS` grants.

## Test plan
- **Reset:** hold `n_rst`=0 with `jw_done`=all ones → all outputs 0. After release, the first grant is worker 0 and `wr_ready` rises 1 cycle after the first IDLE sample.
- **Single write:** `jw_done[3]`=1, `address[3]`=0x0000_1234, `color[3]`=0x00FF_00FF, `wr_done` pulsed 2 cycles after `wr_ready`.
  - `wr_addr`/`wr_data` match and are held.
  - `mc_done[3]` is a single pulse the cycle after `wr_done`.
  - `pixel_count`=1.
- **Round-robin:** all 16 `jw_done` held high, each dropped 1 cycle after its `mc_done` → grant order 0,1,...,15,0. No worker is granted twice consecutively; `mc_busy` equals requesters minus the grant.
- **Fixed priority** (`PRIORITY_MODE`=1): `jw_done[5]` and `jw_done[2]` both high → 2 is granted before 5.
- **Frame wrap** (`FRAME_PIXELS`=4): after 4 writes, `frame_done` pulses on the 4th RELEASE and `pixel_count` returns to 0. `start_sig` in the same cycle as a RELEASE → count 0 and no `frame_done`.
- **Reset mid-WRITE:** assert `n_rst`=0 while `wr_ready`=1 → `wr_ready` falls without a clock edge, no `mc_done` pulses, FSM restarts in IDLE.
